ocd_mem_reader: RTL and testbench

OCD_MEM_READER -- requirements
Module: ocd_mem_reader

---
 rtl/ocd_mem_reader.sv | 161 ++++++++++++++++
 tb/tb_ocd_mem_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocd_mem_reader.sv
// Streams a run of 32-bit words from the MCU on-chip-debug read port out as bytes, little-endian.
// One read is in flight at a time; a read that never answers ends the dump with error set.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 30
`endif

module ocd_mem_reader #(
  parameter int MEM_ADDR_BITS  = `MEM_ADDR_BITS,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     start,
  input  logic [MEM_ADDR_BITS-1:0] start_addr,
  input  logic [15:0]              word_count,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     ocd_read_enable,
  output logic [MEM_ADDR_BITS-1:0] ocd_rw_addr,
  input  logic                     ocd_mem_enable_out,
  input  logic [XLEN-1:0]          ocd_mem_word_out,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [MEM_ADDR_BITS-1:0] addr;
  logic [15:0]              count;
  logic [1:0]               byte_idx;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     tmo_last;
  logic                     hs;
  logic [XLEN-1:0]          word_p0;

  function automatic logic [7:0] select_byte(input logic [XLEN-1:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign tmo_last    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign hs          = (state == SEND) && byte_ready;
  assign ocd_rw_addr = addr;
  assign byte_out    = (state == SEND) ? select_byte(word_p0, byte_idx) : 8'd0;

  // State register and control counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      count    <= '0;
      byte_idx <= '0;
      tmo_cnt  <= '0;
      error    <= 1'b0;
    end else if (sync_reset) begin
      state    <= IDLE;
      addr     <= '0;
      count    <= '0;
      byte_idx <= '0;
      tmo_cnt  <= '0;
      error    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= start_addr;
            count <= word_count;
            error <= 1'b0;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (ocd_mem_enable_out) begin
            byte_idx <= 2'd0;
          end else if (tmo_last) begin
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        SEND: begin
          if (hs) begin
            byte_idx <= byte_idx + 2'd1;
            // Word fully sent: advance to the next address, wrapping at the top
            if (byte_idx == 2'd3) begin
              count <= count - 16'd1;
              addr  <= addr + MEM_ADDR_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data capture; gated by state, so it needs no reset
  always_ff @(posedge clk) begin
    if ((state == WAIT) && ocd_mem_enable_out) begin
      word_p0 <= ocd_mem_word_out;
    end
  end

  always_comb begin
    next_state      = state;
    busy            = (state != IDLE);
    done            = 1'b0;
    ocd_read_enable = 1'b0;
    byte_valid      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (word_count == 16'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        ocd_read_enable = 1'b1;
        next_state      = WAIT;
      end
      WAIT: begin
        if (ocd_mem_enable_out) begin
          next_state = SEND;
        end else if (tmo_last) begin
          next_state = FINISH;
        end
      end
      SEND: begin
        byte_valid = 1'b1;
        if (hs && (byte_idx == 2'd3)) begin
          next_state = (count == 16'd1) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ocd_mem_reader.sv
// Scoreboard bench for ocd_mem_reader: directed dumps against a 1-cycle-latency memory model.
`timescale 1ns/1ps

module tb_ocd_mem_reader;

  localparam int AW  = 30;
  localparam int TMO = 16;

  logic          clk;
  logic          reset_n;
  logic          sync_reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [15:0]   word_count;
  logic          busy;
  logic          done;
  logic          error;
  logic          ocd_read_enable;
  logic [AW-1:0] ocd_rw_addr;
  logic          ocd_mem_enable_out;
  logic [31:0]   ocd_mem_word_out;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;

  ocd_mem_reader #(
    .MEM_ADDR_BITS (AW),
    .XLEN          (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .sync_reset        (sync_reset),
    .start             (start),
    .start_addr        (start_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .ocd_read_enable   (ocd_read_enable),
    .ocd_rw_addr       (ocd_rw_addr),
    .ocd_mem_enable_out(ocd_mem_enable_out),
    .ocd_mem_word_out  (ocd_mem_word_out),
    .byte_out          (byte_out),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]    exp_bytes[$];
  logic          exp_err[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   mem [logic [AW-1:0]];

  int   done_cnt   = 0;
  int   done_cyc   = 0;
  int   strobe_cnt = 0;
  int   strobe_cyc = 0;
  int   bv_cnt     = 0;
  logic in_flight  = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] prev_byte = 8'd0;

  logic model_on   = 1'b1;
  logic late_en    = 1'b0;
  logic rand_mode  = 1'b0;
  logic ready_level = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0_0000;
  endfunction

  always @(posedge clk) cyc++;

  // Memory model: answers a strobe one cycle later
  initial begin
    logic          req;
    logic [AW-1:0] ra;
    ocd_mem_enable_out = 1'b0;
    ocd_mem_word_out   = 32'd0;
    forever begin
      @(negedge clk);
      req = ocd_read_enable;
      ra  = ocd_rw_addr;
      @(posedge clk);
      #1;
      ocd_mem_enable_out = (req && model_on) || late_en;
      ocd_mem_word_out   = req ? rd(ra) : 32'hFFFF_FFFF;
    end
  end

  // Downstream ready driver
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      byte_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (reset_n && !sync_reset) begin
      if (ocd_read_enable) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        check("read_overlap", {31'd0, in_flight}, 32'd0);
        in_flight = 1'b1;
        if (exp_addr.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
        else check("strobe_addr", 32'(ocd_rw_addr), 32'(exp_addr.pop_front()));
      end
      if (ocd_mem_enable_out) in_flight = 1'b0;
      if (byte_valid) bv_cnt++;
      if (byte_valid && stall_prev) check("stall_stable", {24'd0, byte_out}, {24'd0, prev_byte});
      if (byte_valid && byte_ready) begin
        if (exp_bytes.size() == 0) check("byte_unexpected", {24'd0, byte_out}, 32'hFFFF_FFFF);
        else check("byte", {24'd0, byte_out}, {24'd0, exp_bytes.pop_front()});
      end
      stall_prev = byte_valid && !byte_ready;
      prev_byte  = byte_out;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        in_flight = 1'b0;
        if (exp_err.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else check("done_error", {31'd0, error}, {31'd0, exp_err.pop_front()});
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(w[8*i +: 8]);
  endtask

  task automatic start_dump(input logic [AW-1:0] a, input logic [15:0] n, output int launch);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    launch     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n0, input int budget);
    int i = 0;
    while (done_cnt == n0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    check(name, {31'd0, done_cnt != n0}, 32'd1);
  endtask

  task automatic run_two(input string name, input logic [AW-1:0] a0, input logic [31:0] w0,
                         input logic [31:0] w1, input logic poke);
    int n0;
    int launch;
    logic [AW-1:0] a1;
    a1 = a0 + AW'(1);
    mem[a0] = w0;
    mem[a1] = w1;
    exp_addr.push_back(a0);
    exp_addr.push_back(a1);
    push_word(w0);
    push_word(w1);
    exp_err.push_back(1'b0);
    n0 = done_cnt;
    start_dump(a0, 16'd2, launch);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start      = 1'b1;
      start_addr = AW'(32'h123);
      word_count = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done({name, "_done"}, n0, 400);
    @(negedge clk);
    check({name, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},  {31'd0, busy}, 32'd0);
    check({name, "_done"},  {31'd0, done}, 32'd0);
    check({name, "_error"}, {31'd0, error}, 32'd0);
    check({name, "_rd_en"}, {31'd0, ocd_read_enable}, 32'd0);
    check({name, "_bvalid"}, {31'd0, byte_valid}, 32'd0);
    check({name, "_addr"},  32'(ocd_rw_addr), 32'd0);
    check({name, "_byte"},  {24'd0, byte_out}, 32'd0);
  endtask

  task automatic clear_scoreboard();
    exp_bytes.delete();
    exp_err.delete();
    exp_addr.delete();
    in_flight = 1'b0;
  endtask

  task automatic wait_byte_valid(input string name);
    int i = 0;
    while (!byte_valid && i < 50) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, byte_valid}, 32'd1);
  endtask

  initial begin
    int n0;
    int s0;
    int b0;
    int launch;
    reset_n    = 1'b0;
    sync_reset = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Two-word dump, ready always high
    run_two("basic", AW'(32'h8000_0000 >> 2), 32'h0000_0013, 32'h0010_0093, 1'b0);

    // Same dump with random back-pressure and a start pulse while busy
    rand_mode = 1'b1;
    run_two("stall", AW'(32'h8000_0000 >> 2), 32'h0000_0013, 32'h0010_0093, 1'b1);
    rand_mode = 1'b0;

    // Zero-length dump
    s0 = strobe_cnt;
    n0 = done_cnt;
    exp_err.push_back(1'b0);
    start_dump(AW'(32'h40), 16'd0, launch);
    wait_done("zero_done", n0, 20);
    check("zero_latency_edges", 32'(done_cyc + 1 - launch), 32'd2);
    check("zero_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    @(negedge clk);
    check("zero_busy_after", {31'd0, busy}, 32'd0);

    // Read that never answers
    model_on = 1'b0;
    n0 = done_cnt;
    b0 = bv_cnt;
    exp_addr.push_back(AW'(32'h5));
    exp_err.push_back(1'b1);
    start_dump(AW'(32'h5), 16'd1, launch);
    wait_done("tmo_done", n0, 100);
    check("tmo_latency", 32'(done_cyc - strobe_cyc), 32'(TMO + 1));
    check("tmo_no_bvalid", 32'(bv_cnt - b0), 32'd0);
    repeat (2) @(negedge clk);
    check("tmo_error_held", {31'd0, error}, 32'd1);
    model_on = 1'b1;

    // Address wrap from all-ones; this start also clears the held error
    run_two("wrap", {AW{1'b1}}, 32'hA1B2_C3D4, 32'h5566_7788, 1'b0);

    // Asynchronous reset while stalled in SEND, then a late read response
    ready_level = 1'b0;
    mem[AW'(32'h40)] = 32'hCAFE_F00D;
    exp_addr.push_back(AW'(32'h40));
    n0 = done_cnt;
    start_dump(AW'(32'h40), 16'd2, launch);
    @(negedge clk);
    wait_byte_valid("areset_reach_send");
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("areset");
    clear_scoreboard();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    late_en = 1'b1;
    @(negedge clk);
    late_en = 1'b0;
    repeat (2) @(negedge clk);
    check("areset_late_busy", {31'd0, busy}, 32'd0);
    check("areset_late_bvalid", {31'd0, byte_valid}, 32'd0);
    check("areset_no_done", 32'(done_cnt - n0), 32'd0);

    // Synchronous reset while stalled in SEND
    exp_addr.push_back(AW'(32'h40));
    n0 = done_cnt;
    start_dump(AW'(32'h40), 16'd1, launch);
    @(negedge clk);
    wait_byte_valid("sreset_reach_send");
    @(posedge clk);
    #1;
    sync_reset = 1'b1;
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    clear_scoreboard();
    @(negedge clk);
    check_reset_outputs("sreset");
    ready_level = 1'b1;
    repeat (3) @(negedge clk);
    check("sreset_no_done", 32'(done_cnt - n0), 32'd0);

    // Normal operation after both resets
    run_two("post_reset", AW'(32'h100), 32'h0102_0304, 32'hF0E0_D0C0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
